button_press_decoder: RTL and testbench

Consumes the debounced level from the push-button debouncer and turns it into one-cycle event pulses for the clock's time-setting logic.
- short press: released before the long-press threshold.
- long press: held past the threshold.
- auto-repeat: periodic ticks while a long press is held.
It runs in the same clock domain as the debouncer and drives the set/increment controls directly.

---
 rtl/clock_ui_pkg.sv | 23 ++
 rtl/ms_tick.sv | 43 ++++
 rtl/button_press_decoder.sv | 141 ++++++++++++++
 tb/tb_button_press_decoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clock_ui_pkg.sv
// clock_ui_pkg: shared definitions for the clock user-interface blocks.
//   - press_state_t : button_press_decoder FSM encoding (IDLE=0, PRESSED=1, REPEATING=2).
//   - CLK_PER_MS_DEFAULT : ck cycles per millisecond; the debouncer's ms counter uses it too.
//   - cnt_width() : counter width for a modulus, never below 1 bit.
package clock_ui_pkg;

   localparam int unsigned CLK_PER_MS_DEFAULT = 100_000;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StPressed   = 2'd1,
      StRepeating = 2'd2
   } press_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ms_tick.sv
// ms_tick: millisecond prescaler.
//   Counts 0..CLK_PER_MS-1 and asserts tick while the count sits at CLK_PER_MS-1; the count
//   wraps to 0 after a tick. While clear is high the count is held at 0, so the first tick
//   lands exactly CLK_PER_MS cycles after clear drops.
// Ports:
//   ck    in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   clear in   hold the count at 0
//   tick  out  one-cycle millisecond strobe (combinational from the count register)
module ms_tick
   import clock_ui_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT
) (
   input  logic ck,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CntW = cnt_width(CLK_PER_MS);
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_PER_MS - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntMax);

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/button_press_decoder.sv
// button_press_decoder: turns the debounced button level into one-cycle UI events.
//   short_pulse  : release before LONG_MS of hold
//   long_pulse   : hold reaches LONG_MS
//   repeat_pulse : every REPEAT_MS while still held after a long press
//   held         : button currently held (FSM not idle)
// All outputs are registered; the three pulses are mutually exclusive.
// Build option: define AUTO_REPEAT_EN to enable repeat_pulse. Without it repeat_pulse is
// tied to 0 and REPEATING simply waits for release with the hold counter frozen.
// Ports:
//   ck           in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   button_deb   in   debounced button level, synchronous to ck
//   short_pulse  out  see above
//   long_pulse   out  see above
//   repeat_pulse out  see above
//   held         out  see above
module button_press_decoder
   import clock_ui_pkg::*;
#(
   parameter int unsigned CLK_PER_MS = CLK_PER_MS_DEFAULT,
   parameter int unsigned LONG_MS    = 1000,
   parameter int unsigned REPEAT_MS  = 200
) (
   input  logic ck,
   input  logic rst,
   input  logic button_deb,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held
);

   localparam int unsigned HoldW = cnt_width(max_u(LONG_MS, REPEAT_MS));
   localparam logic [HoldW-1:0] LongMax = HoldW'(LONG_MS - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [HoldW-1:0] RepMax = HoldW'(REPEAT_MS - 1);
`endif

   press_state_t     state_q, state_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             short_d, long_d, repeat_d, held_d;
   logic             tick;

   // Prescaler is parked at 0 while idle so every press is timed from its own start.
   ms_tick #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_ms_tick (
      .ck    (ck),
      .rst   (rst),
      .clear (state_q == StIdle),
      .tick  (tick)
   );

   // State and output registers.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         hold_q       <= '0;
         short_pulse  <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         held         <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         short_pulse  <= short_d;
         long_pulse   <= long_d;
         repeat_pulse <= repeat_d;
         held         <= held_d;
      end
   end

   // Next state and hold counter.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         StIdle: begin
            if (button_deb) begin
               state_d = StPressed;
               hold_d  = '0;
            end
         end
         StPressed: begin
            // Release is tested first so it wins over a coincident threshold tick.
            if (!button_deb) begin
               state_d = StIdle;
               hold_d  = '0;
            end else if (tick) begin
               if (hold_q == LongMax) begin
                  state_d = StRepeating;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HoldW'(1);
               end
            end
         end
         StRepeating: begin
            if (!button_deb) begin
               state_d = StIdle;
               hold_d  = '0;
            end
`ifdef AUTO_REPEAT_EN
            else if (tick) begin
               if (hold_q == RepMax) begin
                  hold_d = '0;
               end else begin
                  hold_d = hold_q + HoldW'(1);
               end
            end
`endif
         end
         default: begin
            state_d = StIdle;
            hold_d  = '0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         StPressed: begin
            short_d = !button_deb;
            long_d  = button_deb && tick && (hold_q == LongMax);
         end
         StRepeating: begin
`ifdef AUTO_REPEAT_EN
            repeat_d = button_deb && tick && (hold_q == RepMax);
`endif
         end
         default: ;
      endcase
      // held follows the state one cycle later; an illegal state maps to idle here.
      held_d = (state_d != StIdle);
   end

endmodule

// File: tb/tb_button_press_decoder.sv
module tb_button_press_decoder;

   localparam int unsigned Cpm     = 4;
   localparam int unsigned LongMs  = 5;
   localparam int unsigned RepMs   = 2;
   localparam int          LongCyc = LongMs * Cpm;
   localparam int          RepCyc  = RepMs * Cpm;

   localparam int EvShort  = 1;
   localparam int EvLong   = 2;
   localparam int EvRepeat = 3;

   typedef struct {
      int kind;
      int when;
   } ev_t;

   logic ck = 1'b0;
   logic rst = 1'b1;
   logic button_deb = 1'b0;
   logic short_pulse, long_pulse, repeat_pulse, held;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0 = 0;
   ev_t  sb_q[$];
   ev_t  mon_ev;
   int   mon_kind;
   int   mon_hi;

   always #5 ck = ~ck;

   // cyc equals the index of the most recent rising edge.
   always @(posedge ck) cyc <= cyc + 1;

   button_press_decoder #(
      .CLK_PER_MS (Cpm),
      .LONG_MS    (LongMs),
      .REPEAT_MS  (RepMs)
   ) dut (
      .ck           (ck),
      .rst          (rst),
      .button_deb   (button_deb),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int when);
      ev_t ev;
      ev.kind = kind;
      ev.when = when;
      sb_q.push_back(ev);
   endtask

   // Expected events for a press whose first 1 sample is at edge start and lasts n samples.
   // Event times are in output cycles: a pulse registered at edge e is counted as cycle e+1.
   task automatic expect_press(input int start, input int n);
      if (n <= LongCyc) begin
         push_ev(EvShort, start + n + 1);
      end else begin
         push_ev(EvLong, start + LongCyc + 1);
`ifdef AUTO_REPEAT_EN
         for (int k = 1; LongCyc + k * RepCyc < n; k++) begin
            push_ev(EvRepeat, start + LongCyc + k * RepCyc + 1);
         end
`endif
      end
   endtask

   // Called at a falling edge; drives n samples of 1 then drops the button.
   task automatic press(input int n);
      check("held_pre", held, 0);
      button_deb = 1'b1;
      t0 = cyc + 1;
      expect_press(t0, n);
      for (int i = 0; i < n; i++) begin
         @(negedge ck);
         check("held_on", held, 1);
      end
      button_deb = 1'b0;
   endtask

   task automatic gap(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge ck);
         check("held_off", held, 0);
      end
   endtask

   // Scoreboard side: every pulse seen must match the head of the expected queue.
   always @(negedge ck) begin
      mon_hi = int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse);
      if (mon_hi != 0) begin
         check("pulse_exclusive", mon_hi, 1);
         mon_kind = short_pulse ? EvShort : (long_pulse ? EvLong : EvRepeat);
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", mon_kind, 0);
         end else begin
            mon_ev = sb_q.pop_front();
            check("pulse_kind", mon_kind, mon_ev.kind);
            check("pulse_cycle", cyc + 1, mon_ev.when);
         end
      end
   end

   initial begin
      // Reset state.
      for (int i = 0; i < 3; i++) begin
         @(negedge ck);
         check("rst_held", held, 0);
         check("rst_short", short_pulse, 0);
         check("rst_long", long_pulse, 0);
         check("rst_repeat", repeat_pulse, 0);
      end
      rst = 1'b0;
      gap(3);

      press(10);              // short press
      gap(3);
      press(40);              // long press with auto-repeat
      gap(3);
      press(LongCyc);         // release on the long-threshold tick: short only
      gap(3);
      press(LongCyc + RepCyc); // release on the first repeat tick: long only
      gap(3);

      // Reset mid-hold with the button still down.
      check("held_pre", held, 0);
      button_deb = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge ck);
         check("held_on", held, 1);
      end
      rst = 1'b1;
      #1;
      check("midrst_held", held, 0);
      check("midrst_short", short_pulse, 0);
      check("midrst_long", long_pulse, 0);
      check("midrst_repeat", repeat_pulse, 0);
      @(negedge ck);
      check("midrst_held2", held, 0);
      @(negedge ck);
      check("midrst_held3", held, 0);
      rst = 1'b0;
      press(LongCyc + 2);     // fresh press starts at the first edge after deassert
      gap(3);

      // Back-to-back short presses with a single low sample between them.
      press(3);
      gap(1);
      press(3);
      gap(6);

      check("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
